// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/compare ops plus an optional WIDTH-cycle shift-add multiply.
// Latency: 1 cycle accept-to-out_valid for single-cycle ops, WIDTH+1 cycles for multiply.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE, so no accept on the consume cycle.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       bonus_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SET  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic               sub_op;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   sum_low;
    logic               add_ovf;
    logic               is_eq;
    logic               is_lt;
    logic               set_cond;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;
    logic               alu_ill;

    // New work is only taken while idle; the decision depends on state alone.
    assign in_ready = (state == IDLE);

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // Single-cycle datapath; SET shares the subtractor and derives signed-less from sign XOR overflow.
    always_comb begin
        sub_op   = (ALU_control == OP_SUB) || (ALU_control == OP_SET);
        b_eff    = sub_op ? ~src2 : src2;
        sum_full = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
        sum_low  = {1'b0, src1[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub_op};
        add_ovf  = sum_low[WIDTH-1] ^ sum_full[WIDTH];
        is_eq    = (src1 == src2);
        is_lt    = sum_full[WIDTH-1] ^ add_ovf;
        set_cond = 1'b0;
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        case (ALU_control)
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_NOR:  alu_res = ~(src1 | src2);
            OP_NAND: alu_res = ~(src1 & src2);
            OP_ADD, OP_SUB: begin
                alu_res  = sum_full[WIDTH-1:0];
                alu_cout = sum_full[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SET: begin
                case (bonus_control)
                    3'b000:  set_cond = is_lt;
                    3'b001:  set_cond = !is_lt && !is_eq;
                    3'b010:  set_cond = is_lt || is_eq;
                    3'b011:  set_cond = !is_lt;
                    3'b100:  set_cond = is_eq;
                    3'b101:  set_cond = !is_eq;
                    default: alu_ill  = 1'b1;
                endcase
                alu_res = {{(WIDTH-1){1'b0}}, set_cond};
            end
            // Only reaches here when multiply is disabled; otherwise IDLE routes it to MUL.
            OP_MUL:  alu_ill = (MUL_EN == 0);
            default: alu_ill = 1'b1;
        endcase
    end

    // Control FSM with registered result/flags; reset aborts any in-flight multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if ((MUL_EN != 0) && (ALU_control == OP_MUL)) begin
                            state  <= MUL;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, src1};
                            mplier <= src2;
                            cnt    <= '0;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            cout      <= alu_cout;
                            overflow  <= alu_ovf;
                            illegal   <= alu_ill;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        result    <= acc_next[WIDTH-1:0];
                        zero      <= (acc_next[WIDTH-1:0] == '0);
                        cout      <= 1'b0;
                        overflow  <= |acc_next[2*WIDTH-1:WIDTH];
                        illegal   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (32-bit, 8-bit, 8-bit without multiply) share operand lines.
// Each op is issued to one instance, its latency and registered outputs compared with a reference model.
// Consume is always attempted with in_valid high to show that no new op is accepted on that cycle.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src1, src2;
    logic [3:0]  ALU_control;
    logic [2:0]  bonus_control;
    logic [2:0]  in_valid, out_ready;

    logic        ir32, ov32, z32, c32, v32, il32;
    logic [31:0] res32;
    logic        ir8, ov8, z8, c8, v8, il8;
    logic [7:0]  res8;
    logic        irn, ovn, zn, cn, vn, iln;
    logic [7:0]  resn;

    int          vectors = 0;
    int          miscompares = 0;
    int          sel = 0;

    logic        o_vld, o_rdy;
    logic [67:0] o_vec;

    typedef struct packed {
        logic [1:0]  s;
        logic [3:0]  op;
        logic [2:0]  bo;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  lat;
        logic [67:0] exp;
    } dvec_t;

    // {illegal, overflow, cout, zero, result zero-extended to 64}
    dvec_t dtbl [0:8] = '{
        '{2'd0, 4'b0010, 3'd0, 32'h7FFFFFFF, 32'h1, 8'd1, {4'b0100, 64'h80000000}},
        '{2'd0, 4'b0110, 3'd0, 32'h5,        32'h5, 8'd1, {4'b0011, 64'h0}},
        '{2'd0, 4'b0111, 3'd4, 32'h5,        32'h5, 8'd1, {4'b0000, 64'h1}},
        '{2'd1, 4'b0111, 3'd0, 32'h80,       32'h1, 8'd1, {4'b0000, 64'h1}},
        '{2'd1, 4'b0111, 3'd3, 32'h80,       32'h1, 8'd1, {4'b0001, 64'h0}},
        '{2'd1, 4'b1000, 3'd0, 32'h10,       32'h11, 8'd9, {4'b0100, 64'h10}},
        '{2'd2, 4'b1000, 3'd0, 32'h10,       32'h11, 8'd1, {4'b1001, 64'h0}},
        '{2'd1, 4'b1111, 3'd0, 32'h3,        32'h4, 8'd1, {4'b1001, 64'h0}},
        '{2'd1, 4'b0111, 3'd6, 32'h3,        32'h3, 8'd1, {4'b1001, 64'h0}}
    };

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            0: begin
                o_vld = ov32; o_rdy = ir32;
                o_vec = {il32, v32, c32, z32, 32'd0, res32};
            end
            1: begin
                o_vld = ov8; o_rdy = ir8;
                o_vec = {il8, v8, c8, z8, 56'd0, res8};
            end
            default: begin
                o_vld = ovn; o_rdy = irn;
                o_vec = {iln, vn, cn, zn, 56'd0, resn};
            end
        endcase
    end

    alu_seq #(.WIDTH(32), .MUL_EN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir32),
        .src1(src1), .src2(src2), .ALU_control(ALU_control), .bonus_control(bonus_control),
        .out_valid(ov32), .out_ready(out_ready[0]), .result(res32),
        .zero(z32), .cout(c32), .overflow(v32), .illegal(il32)
    );

    alu_seq #(.WIDTH(8), .MUL_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir8),
        .src1(src1[7:0]), .src2(src2[7:0]), .ALU_control(ALU_control), .bonus_control(bonus_control),
        .out_valid(ov8), .out_ready(out_ready[1]), .result(res8),
        .zero(z8), .cout(c8), .overflow(v8), .illegal(il8)
    );

    alu_seq #(.WIDTH(8), .MUL_EN(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(irn),
        .src1(src1[7:0]), .src2(src2[7:0]), .ALU_control(ALU_control), .bonus_control(bonus_control),
        .out_valid(ovn), .out_ready(out_ready[2]), .result(resn),
        .zero(zn), .cout(cn), .overflow(vn), .illegal(iln)
    );

    // Reference: plain integer arithmetic on masked / sign-extended values.
    function automatic logic [67:0] model(input int w, input bit me, input logic [3:0] op,
                                          input logic [2:0] bo, input logic [31:0] ai,
                                          input logic [31:0] bi);
        logic [63:0] m, a, b, r, p;
        longint      sa, sb, d, lim;
        logic        c, v, il, cond;
        m   = (64'd1 << w) - 64'd1;
        a   = {32'd0, ai} & m;
        b   = {32'd0, bi} & m;
        sa  = longint'(a);
        sb  = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        lim = longint'(1) << (w - 1);
        r = 64'd0; c = 1'b0; v = 1'b0; il = 1'b0; cond = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b) & m;
            4'b1101: r = ~(a & b) & m;
            4'b0010: begin
                r = (a + b) & m;
                c = ((a + b) >> w) != 64'd0;
                d = sa + sb;
                v = (d >= lim) || (d < -lim);
            end
            4'b0110: begin
                r = (a - b) & m;
                c = (a >= b);
                d = sa - sb;
                v = (d >= lim) || (d < -lim);
            end
            4'b0111: begin
                case (bo)
                    3'd0: cond = (sa < sb);
                    3'd1: cond = (sa > sb);
                    3'd2: cond = (sa <= sb);
                    3'd3: cond = (sa >= sb);
                    3'd4: cond = (a == b);
                    3'd5: cond = (a != b);
                    default: il = 1'b1;
                endcase
                r = {63'd0, cond};
            end
            4'b1000: begin
                if (me) begin
                    p = a * b;
                    r = p & m;
                    v = (p >> w) != 64'd0;
                end else begin
                    il = 1'b1;
                end
            end
            default: il = 1'b1;
        endcase
        return {il, v, c, (r == 64'd0), r};
    endfunction

    // Present one op to instance s, then scramble inputs while waiting for out_valid.
    task automatic issue(input int s, input logic [3:0] op, input logic [2:0] bo,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok);
        sel = s;
        src1 = a; src2 = b; ALU_control = op; bonus_control = bo;
        in_valid = 3'b000;
        in_valid[s] = 1'b1;
        @(negedge clk);
        in_valid[s] = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!o_vld && lat < 200) begin
            if (o_rdy) busy_ok = 1'b0;
            src1 = $urandom; src2 = $urandom;
            ALU_control = 4'($urandom); bonus_control = 3'($urandom);
            in_valid[s] = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid[s] = 1'b0;
    endtask

    // Accept the result while also offering a new op; reports state one cycle later.
    task automatic consume(input int s, output logic v, output logic r);
        out_ready[s] = 1'b1;
        in_valid[s] = 1'b1;
        ALU_control = 4'b0000;
        @(negedge clk);
        v = o_vld;
        r = o_rdy;
        out_ready[s] = 1'b0;
        in_valid[s] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 3'b111; out_ready = 3'b111;
        src1 = 32'h7FFFFFFF; src2 = 32'h1; ALU_control = 4'b0010; bonus_control = 3'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            vectors++;
            if ({o_vld, o_rdy, o_vec} !== {1'b0, 1'b1, 68'd0}) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got vld=%b rdy=%b vec=%h want vld=0 rdy=1 vec=0",
                         s, o_vld, o_rdy, o_vec);
            end
        end
        in_valid = 3'b000; out_ready = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int   lat;
        logic bok, v, r;
        for (int i = 0; i < 9; i++) begin
            issue(int'(dtbl[i].s), dtbl[i].op, dtbl[i].bo, dtbl[i].a, dtbl[i].b, lat, bok);
            vectors++;
            if (lat !== int'(dtbl[i].lat)) begin
                miscompares++;
                $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, dtbl[i].lat);
            end
            vectors++;
            if (o_vec !== dtbl[i].exp) begin
                miscompares++;
                $display("FAIL directed%0d_outputs: got %h want %h", i, o_vec, dtbl[i].exp);
            end
            if (dtbl[i].lat > 8'd1) begin
                vectors++;
                if (bok !== 1'b1) begin
                    miscompares++;
                    $display("FAIL directed%0d_in_ready_busy: got in_ready=1 during op want 0", i);
                end
            end
            consume(int'(dtbl[i].s), v, r);
            vectors++;
            if ({v, r} !== 2'b01) begin
                miscompares++;
                $display("FAIL directed%0d_consume: got vld=%b rdy=%b want vld=0 rdy=1", i, v, r);
            end
        end
    endtask

    task automatic test_hold();
        int          lat;
        logic        bok, v, r;
        logic [67:0] exp;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        exp = model(32, 1'b1, 4'b0010, 3'd0, a, b);
        issue(0, 4'b0010, 3'd0, a, b, lat, bok);
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            src1 = $urandom; src2 = $urandom; ALU_control = 4'b0110;
            @(negedge clk);
            vectors++;
            if ({o_vld, o_rdy, o_vec} !== {1'b1, 1'b0, exp}) begin
                miscompares++;
                $display("FAIL hold_stable cycle %0d: got vld=%b rdy=%b vec=%h want vld=1 rdy=0 vec=%h",
                         k, o_vld, o_rdy, o_vec, exp);
            end
        end
        in_valid[0] = 1'b0;
        consume(0, v, r);
        vectors++;
        if ({v, r} !== 2'b01) begin
            miscompares++;
            $display("FAIL hold_release: got vld=%b rdy=%b want vld=0 rdy=1", v, r);
        end
    endtask

    task automatic test_reset_mid_mul();
        int   lat;
        logic bok, v, r;
        sel = 1;
        src1 = 32'hFF; src2 = 32'hFF; ALU_control = 4'b1000; bonus_control = 3'd0;
        in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        in_valid[1] = 1'b1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b0;
        vectors++;
        if ({o_vld, o_rdy, o_vec} !== {1'b0, 1'b1, 68'd0}) begin
            miscompares++;
            $display("FAIL mid_mul_reset: got vld=%b rdy=%b vec=%h want vld=0 rdy=1 vec=0",
                     o_vld, o_rdy, o_vec);
        end
        repeat (12) @(negedge clk);
        vectors++;
        if (o_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL aborted_mul_output: got out_valid=%b want 0", o_vld);
        end
        issue(1, 4'b1111, 3'd0, 32'h5A, 32'hA5, lat, bok);
        vectors++;
        if ({lat == 1, o_vec} !== {1'b1, 4'b1001, 64'd0}) begin
            miscompares++;
            $display("FAIL illegal_after_reset: got lat=%0d vec=%h want lat=1 vec=%h",
                     lat, o_vec, {4'b1001, 64'd0});
        end
        consume(1, v, r);
    endtask

    task automatic test_random();
        logic [3:0]  ops [0:7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                   4'b0111, 4'b1100, 4'b1101, 4'b1000};
        int          s, w, lat, elat, idx;
        bit          me;
        logic        bok, v, r;
        logic [3:0]  op;
        logic [2:0]  bo;
        logic [31:0] a, b;
        logic [67:0] exp;
        for (int i = 0; i < 150; i++) begin
            s   = $urandom_range(0, 2);
            w   = (s == 0) ? 32 : 8;
            me  = (s != 2);
            idx = $urandom_range(0, 8);
            op  = (idx == 8) ? 4'($urandom) : ops[idx];
            bo  = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h80000080;
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            exp  = model(w, me, op, bo, a, b);
            elat = (op == 4'b1000 && me) ? w + 1 : 1;
            issue(s, op, bo, a, b, lat, bok);
            vectors++;
            if (lat !== elat) begin
                miscompares++;
                $display("FAIL rand%0d_latency op=%b w=%0d: got %0d want %0d", i, op, w, lat, elat);
            end
            vectors++;
            if (o_vec !== exp) begin
                miscompares++;
                $display("FAIL rand%0d_outputs op=%b bo=%b a=%h b=%h w=%0d: got %h want %h",
                         i, op, bo, a, b, w, o_vec, exp);
            end
            if (elat > 1) begin
                vectors++;
                if (bok !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rand%0d_in_ready_busy: got in_ready=1 during multiply want 0", i);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            vectors++;
            if ({o_vld, o_vec} !== {1'b1, exp}) begin
                miscompares++;
                $display("FAIL rand%0d_stall: got vld=%b vec=%h want vld=1 vec=%h", i, o_vld, o_vec, exp);
            end
            consume(s, v, r);
            vectors++;
            if ({v, r} !== 2'b01) begin
                miscompares++;
                $display("FAIL rand%0d_consume: got vld=%b rdy=%b want vld=0 rdy=1", i, v, r);
            end
        end
    endtask

    initial begin
        in_valid = 3'b000;
        out_ready = 3'b000;
        rst_n = 1'b0;
        src1 = '0; src2 = '0; ALU_control = '0; bonus_control = '0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
